aes_key_expander: RTL and testbench

// - AES key schedule plus round-key memory for the AES core; supports AES-128 and AES-256.
// - On init, expands the key into 11 (AES-128) or 15 (AES-256) 128-bit round keys.
// - Expansion runs at one round key per cycle and uses an external shared S-box (sboxw/new_sboxw).
// - The cipher datapath then reads round keys by index through a combinational port.

---
 rtl/aes_key_expander_if.sv | 15 +
 rtl/aes_key_expander.sv | 98 +++++++++
 tb/tb_aes_key_expander.sv | 134 +++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if: key load, round-key read and shared S-box signals of aes_key_expander
//   master : drives key/keylen/init/round and returns the S-box result new_sboxw
//   slave  : the key expander; returns round_key/ready and the S-box request sboxw
interface aes_key_expander_if;
  logic [255:0] key;
  logic         keylen;
  logic         init;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  modport master (output key, keylen, init, round, new_sboxw, input round_key, ready, sboxw);
  modport slave (input key, keylen, init, round, new_sboxw, output round_key, ready, sboxw);
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128/256 key schedule with 15-entry round-key memory and combinational read
//   clk, reset_n (async, active-low)
//   bus.key/keylen/init : key load, init pulse accepted only when idle
//   bus.round/round_key : combinational round-key read, valid while bus.ready = 1
//   bus.sboxw/new_sboxw : word sent to / returned from the shared S-box, same cycle
//   Optional AES_KEY_MEM_RANGE_CHECK_EN: read of an index past the last round returns 0
module aes_key_expander (
  input logic clk,
  input logic reset_n,
  aes_key_expander_if.slave bus
);
  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;
  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;
  typedef enum logic [1:0] {IDLE, INIT, GENERATE, DONE} state_t;
  state_t state, state_nxt;
  logic [127:0] key_mem [0:14];
  logic [255:0] key_r;
  logic         keylen_r;
  logic [3:0]   round_ctr;
  logic [7:0]   rcon;
  logic [7:0]   rcon_nxt;
  logic         ready_r;
  logic [3:0]   last_round;
  logic [127:0] prev_key;
  logic [127:0] prev2_key;
  logic [127:0] base;
  logic [127:0] new_key;
  logic [31:0]  t;
  logic [31:0]  w0;
  logic [31:0]  w1;
  logic [31:0]  w2;
  logic [31:0]  w3;
  logic         odd256;
  logic         rcon_step;
  assign last_round = (keylen_r == AES_128_BIT_KEY) ? AES128_ROUNDS : AES256_ROUNDS;
  // Previous keys come straight from the memory; the guards keep the index in range.
  assign prev_key  = (round_ctr == 4'd0) ? '0 : key_mem[round_ctr - 4'd1];
  assign prev2_key = (round_ctr < 4'd2) ? '0 : key_mem[round_ctr - 4'd2];
  assign bus.sboxw = prev_key[31:0];
  // Odd AES-256 rounds use SubWord only; all other generated rounds use RotWord and a fresh rcon.
  assign odd256    = (keylen_r == AES_256_BIT_KEY) && round_ctr[0];
  assign rcon_step = (round_ctr != 4'd0) && !odd256;
  assign rcon_nxt  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign t    = odd256 ? bus.new_sboxw : ({bus.new_sboxw[23:0], bus.new_sboxw[31:24]} ^ {rcon_nxt, 24'h0});
  assign base = (keylen_r == AES_256_BIT_KEY) ? prev2_key : prev_key;
  assign w0 = base[127:96] ^ t;
  assign w1 = base[95:64] ^ w0;
  assign w2 = base[63:32] ^ w1;
  assign w3 = base[31:0] ^ w2;
  assign new_key = (round_ctr == 4'd0) ? key_r[255:128] :
                   (round_ctr == 4'd1 && keylen_r == AES_256_BIT_KEY) ? key_r[127:0] : {w0, w1, w2, w3};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = bus.init ? INIT : IDLE;
      INIT:     state_nxt = GENERATE;
      GENERATE: state_nxt = (round_ctr == last_round) ? DONE : GENERATE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) key_mem[i] <= '0;
      key_r     <= '0;
      keylen_r  <= AES_128_BIT_KEY;
      round_ctr <= '0;
      rcon      <= 8'h8d;
      ready_r   <= 1'b0;
    end else begin
      if (state == IDLE && bus.init) begin
        key_r    <= bus.key;
        keylen_r <= bus.keylen;
        ready_r  <= 1'b0;
      end
      if (state == INIT) begin
        round_ctr <= '0;
        rcon      <= 8'h8d;
      end
      if (state == GENERATE) begin
        key_mem[round_ctr] <= new_key;
        round_ctr          <= round_ctr + 4'd1;
        if (rcon_step) rcon <= rcon_nxt;
      end
      if (state == DONE) ready_r <= 1'b1;
    end
  assign bus.ready = ready_r;
`ifdef AES_KEY_MEM_RANGE_CHECK_EN
  assign bus.round_key = (bus.round > last_round) ? '0 : key_mem[bus.round];
`else
  assign bus.round_key = (bus.round == 4'd15) ? '0 : key_mem[bus.round];
`endif
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed self-checking bench for aes_key_expander with a GF(2^8) S-box model
module tb_aes_key_expander;
  logic clk;
  logic reset_n;
  logic use_sbox;
  int passed;
  int total;
  aes_key_expander_if bus ();
  aes_key_expander dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box = affine(x^254); x^254 is the multiplicative inverse, 0 maps to 0.
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      b = gmul(b, b);
      if (i != 0) b = gmul(b, v);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  assign bus.new_sboxw = use_sbox ? {sbox(bus.sboxw[31:24]), sbox(bus.sboxw[23:16]),
                                     sbox(bus.sboxw[15:8]), sbox(bus.sboxw[7:0])} : 32'h0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic rd(input logic [3:0] r, input logic [127:0] exp, input string tag);
    bus.round = r;
    #1;
    chk(tag, bus.round_key, exp);
  endtask
  // Leaves the bench 1 time unit after edge 0 (the edge that samples init).
  task automatic start(input logic [255:0] k, input logic kl);
    @(negedge clk);
    bus.key = k;
    bus.keylen = kl;
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    bus.init = 1'b0;
  endtask
  task automatic wait_ready(input int edge_n, input string tag);
    repeat (edge_n - 1) @(posedge clk);
    #1;
    chk({tag, "_early"}, {127'b0, bus.ready}, 128'h0);
    @(posedge clk);
    #1;
    chk(tag, {127'b0, bus.ready}, 128'h1);
  endtask
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  initial begin
    passed = 0;
    total = 0;
    use_sbox = 1'b0;
    reset_n = 1'b0;
    bus.key = '0;
    bus.keylen = 1'b0;
    bus.init = 1'b0;
    bus.round = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {127'b0, bus.ready}, 128'h0);
    rd(4'd0, 128'h0, "reset_round0");
    @(negedge clk);
    reset_n = 1'b1;
    start(256'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    wait_ready(13, "zero_sbox_ready13");
    rd(4'd0, 128'h0, "zero_sbox_round0");
    rd(4'd1, 128'h01000000010000000100000001000000, "zero_sbox_round1");
    rd(4'd2, 128'h03000000020000000300000002000000, "zero_sbox_round2");
    rd(4'd11, 128'h0, "beyond_last_round11");
    rd(4'd15, 128'h0, "index15");
    use_sbox = 1'b1;
    start({K128, 128'h0}, 1'b0);
    wait_ready(13, "aes128_ready13");
    rd(4'd0, K128, "aes128_round0");
    rd(4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "aes128_round1");
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "aes128_round10");
    start(K256, 1'b1);
    wait_ready(17, "aes256_ready17");
    rd(4'd0, K256[255:128], "aes256_round0");
    rd(4'd1, K256[127:0], "aes256_round1");
    rd(4'd2, 128'ha573c29fa176c498a97fce93a572c09c, "aes256_round2");
    rd(4'd3, 128'h1651a8cd0244beda1a5da4c10640bade, "aes256_round3");
    rd(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "aes256_round14");
    start({K128, 128'h0}, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.key = '1;
    bus.keylen = 1'b1;
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    bus.init = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("midinit_ready_early", {127'b0, bus.ready}, 128'h0);
    @(posedge clk);
    #1;
    chk("midinit_ready13", {127'b0, bus.ready}, 128'h1);
    rd(4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "midinit_round1");
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "midinit_round10");
    start(K256, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_ready", {127'b0, bus.ready}, 128'h0);
    rd(4'd0, 128'h0, "midreset_round0");
    rd(4'd2, 128'h0, "midreset_round2");
    rd(4'd10, 128'h0, "midreset_round10");
    @(negedge clk);
    reset_n = 1'b1;
    start(K256, 1'b1);
    wait_ready(17, "reinit_ready17");
    rd(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "reinit_round14");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
